// File: rtl/conv_seq_pkg.sv
// rtl/conv_seq_pkg.sv - shared state type, width helpers and packing constants for conv_window_sequencer
package conv_seq_pkg;

   localparam int DATA_SIZE       = 8;
   localparam int KERNEL_WIDTH    = 3;
   localparam int NUM_OUT_CHANNEL = 3;
   localparam int NUM_REGISTER    = 256;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHECK,
      S_READ,
      S_ISSUE,
      S_WAIT,
      S_WRITE,
      S_DONE
   } seq_state_e;

   function automatic int addr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int win_bits(input int k, input int ds);
      return k * k * ds;
   endfunction

   function automatic int res_bits(input int c, input int ds);
      return c * ds;
   endfunction

   localparam int WIN_W = win_bits(KERNEL_WIDTH, DATA_SIZE);
   localparam int RES_W = res_bits(NUM_OUT_CHANNEL, DATA_SIZE);

endpackage

// File: rtl/conv_addr_gen.sv
// rtl/conv_addr_gen.sv - pixel/window/channel counters, buffer addresses and layer bounds check
module conv_addr_gen
   import conv_seq_pkg::*;
#(
   parameter int  kernelWidth   = KERNEL_WIDTH,
   parameter int  numOutChannel = NUM_OUT_CHANNEL,
   parameter int  numRegister   = NUM_REGISTER,
   localparam int addrW         = addr_width(numRegister),
   localparam int kW            = cnt_width(kernelWidth),
   localparam int cW            = cnt_width(numOutChannel),
   localparam int LW            = 16 + addrW
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             load_i,
   input  logic [15:0]      width_i,
   input  logic [addrW-1:0] ifmap_base_i,
   input  logic [addrW-1:0] ofmap_base_i,
   input  logic             rd_step_i,
   input  logic             wr_step_i,
   output logic [addrW-1:0] rd_addr_o,
   output logic [addrW-1:0] wb_addr_o,
   output logic [cW-1:0]    ch_idx_o,
   output logic             cfg_err_o,
   output logic             win_last_o,
   output logic             ch_last_o,
   output logic             pix_last_o
);

   logic [15:0]      w_q, w_d, ox_q, ox_d, oy_q, oy_d;
   logic [addrW-1:0] ifb_q, ifb_d, ofb_q, ofb_d;
   logic [kW-1:0]    kx_q, kx_d, ky_q, ky_d;
   logic [cW-1:0]    c_q, c_d;
   logic [15:0]      ow;
   logic [LW-1:0]    w_x, ow_x, ox_x, oy_x, kx_x, ky_x, c_x, ifb_x, ofb_x, nreg_x;

   assign ow     = w_q - 16'(kernelWidth - 1);
   assign w_x    = LW'(w_q);
   assign ow_x   = LW'(ow);
   assign ox_x   = LW'(ox_q);
   assign oy_x   = LW'(oy_q);
   assign kx_x   = LW'(kx_q);
   assign ky_x   = LW'(ky_q);
   assign c_x    = LW'(c_q);
   assign ifb_x  = LW'(ifb_q);
   assign ofb_x  = LW'(ofb_q);
   assign nreg_x = LW'(numRegister);

   // Rejecting W > depth first keeps W^2 and OW^2*C inside LW bits
   assign cfg_err_o = (w_q < 16'(kernelWidth)) || (w_x > nreg_x) ||
                      ((ifb_x + w_x * w_x) > nreg_x) ||
                      ((ofb_x + ow_x * ow_x * LW'(numOutChannel)) > nreg_x);

   assign rd_addr_o  = addrW'(ifb_x + (oy_x + ky_x) * w_x + ox_x + kx_x);
   assign wb_addr_o  = addrW'(ofb_x + (oy_x * ow_x + ox_x) * LW'(numOutChannel) + c_x);
   assign ch_idx_o   = c_q;
   assign win_last_o = (kx_q == kW'(kernelWidth - 1)) && (ky_q == kW'(kernelWidth - 1));
   assign ch_last_o  = (c_q == cW'(numOutChannel - 1));
   assign pix_last_o = (ox_q == ow - 16'd1) && (oy_q == ow - 16'd1);

   always_comb begin
      w_d   = w_q;
      ifb_d = ifb_q;
      ofb_d = ofb_q;
      ox_d  = ox_q;
      oy_d  = oy_q;
      kx_d  = kx_q;
      ky_d  = ky_q;
      c_d   = c_q;
      if (load_i) begin
         w_d   = width_i;
         ifb_d = ifmap_base_i;
         ofb_d = ofmap_base_i;
         ox_d  = '0;
         oy_d  = '0;
         kx_d  = '0;
         ky_d  = '0;
         c_d   = '0;
      end else begin
         if (rd_step_i) begin
            if (kx_q == kW'(kernelWidth - 1)) begin
               kx_d = '0;
               ky_d = (ky_q == kW'(kernelWidth - 1)) ? '0 : ky_q + kW'(1);
            end else begin
               kx_d = kx_q + kW'(1);
            end
         end
         if (wr_step_i) begin
            if (c_q == cW'(numOutChannel - 1)) begin
               c_d = '0;
               if (ox_q == ow - 16'd1) begin
                  ox_d = '0;
                  oy_d = oy_q + 16'd1;
               end else begin
                  ox_d = ox_q + 16'd1;
               end
            end else begin
               c_d = c_q + cW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         w_q   <= '0;
         ifb_q <= '0;
         ofb_q <= '0;
         ox_q  <= '0;
         oy_q  <= '0;
         kx_q  <= '0;
         ky_q  <= '0;
         c_q   <= '0;
      end else begin
         w_q   <= w_d;
         ifb_q <= ifb_d;
         ofb_q <= ofb_d;
         ox_q  <= ox_d;
         oy_q  <= oy_d;
         kx_q  <= kx_d;
         ky_q  <= ky_d;
         c_q   <= c_d;
      end
   end

endmodule

// File: rtl/conv_window_sequencer.sv
// rtl/conv_window_sequencer.sv - sequences one conv layer: window reads, PE handoff, result writeback
// CONV_SEQ_RELU_EN: when defined, negative result bytes are written back as zero.
module conv_window_sequencer
   import conv_seq_pkg::*;
#(
   parameter int  dataSize      = DATA_SIZE,
   parameter int  kernelWidth   = KERNEL_WIDTH,
   parameter int  numOutChannel = NUM_OUT_CHANNEL,
   parameter int  numRegister   = NUM_REGISTER,
   localparam int addrW         = addr_width(numRegister),
   localparam int winW          = win_bits(kernelWidth, dataSize),
   localparam int resW          = res_bits(numOutChannel, dataSize),
   localparam int cW            = cnt_width(numOutChannel)
) (
   input  logic                clk,
   input  logic                nrst,
   input  logic                ctrl_start,
   input  logic [15:0]         cfg_ifmap_width,
   input  logic [addrW-1:0]    cfg_ifmap_base,
   input  logic [addrW-1:0]    cfg_ofmap_base,
   output logic                rd_en,
   output logic [addrW-1:0]    rd_addr,
   input  logic [dataSize-1:0] rd_data,
   output logic                window_valid,
   output logic [winW-1:0]     window_data,
   input  logic                result_valid,
   input  logic [resW-1:0]     result_data,
   output logic                wb_en,
   output logic [addrW-1:0]    wb_addr,
   output logic [dataSize-1:0] wb_data,
   output logic                flag_busy,
   output logic                flag_done,
   output logic                flag_err
);

   seq_state_e          state_q, state_d;
   logic                rd_en_q, wb_en_q, win_vld_q, busy_q, done_q, err_q, rd_vld_q;
   logic [winW-1:0]     win_q, win_shift;
   logic [resW-1:0]     res_q, res_in;
   logic [dataSize-1:0] wb_byte;
   logic [cW-1:0]       ch_idx;
   logic                load, cfg_err, win_last, ch_last, pix_last;

   assign load = (state_q == S_IDLE) && ctrl_start;

   conv_addr_gen #(
      .kernelWidth   (kernelWidth),
      .numOutChannel (numOutChannel),
      .numRegister   (numRegister)
   ) u_addr_gen (
      .clk_i        (clk),
      .rst_ni       (nrst),
      .load_i       (load),
      .width_i      (cfg_ifmap_width),
      .ifmap_base_i (cfg_ifmap_base),
      .ofmap_base_i (cfg_ofmap_base),
      .rd_step_i    (state_q == S_READ),
      .wr_step_i    (state_q == S_WRITE),
      .rd_addr_o    (rd_addr),
      .wb_addr_o    (wb_addr),
      .ch_idx_o     (ch_idx),
      .cfg_err_o    (cfg_err),
      .win_last_o   (win_last),
      .ch_last_o    (ch_last),
      .pix_last_o   (pix_last)
   );

   // Oldest read ends up at element 0 after K^2 shifts
   assign win_shift = {rd_data, win_q[winW-1:dataSize]};

   always_comb begin
      res_in = result_data;
`ifdef CONV_SEQ_RELU_EN
      for (int c = 0; c < numOutChannel; c++) begin
         if (result_data[c*dataSize + dataSize - 1]) res_in[c*dataSize +: dataSize] = '0;
      end
`endif
   end

   always_comb begin
      wb_byte = '0;
      for (int c = 0; c < numOutChannel; c++) begin
         if (ch_idx == cW'(c)) wb_byte = res_q[c*dataSize +: dataSize];
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (ctrl_start) state_d = S_CHECK;
         S_CHECK: state_d = cfg_err ? S_IDLE : S_READ;
         S_READ:  if (win_last) state_d = S_ISSUE;
         S_ISSUE: state_d = S_WAIT;
         S_WAIT:  if (result_valid) state_d = S_WRITE;
         S_WRITE: if (ch_last) state_d = pix_last ? S_DONE : S_READ;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q   <= S_IDLE;
         rd_en_q   <= 1'b0;
         wb_en_q   <= 1'b0;
         win_vld_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         rd_vld_q  <= 1'b0;
         win_q     <= '0;
         res_q     <= '0;
      end else begin
         state_q   <= state_d;
         rd_en_q   <= (state_d == S_READ);
         wb_en_q   <= (state_d == S_WRITE);
         win_vld_q <= (state_d == S_ISSUE);
         busy_q    <= (state_d != S_IDLE);
         done_q    <= (state_d == S_DONE);
         rd_vld_q  <= rd_en_q;
         if (rd_vld_q) win_q <= win_shift;
         if ((state_q == S_WAIT) && result_valid) res_q <= res_in;
         if (load) err_q <= 1'b0;
         if ((state_q == S_CHECK) && cfg_err) err_q <= 1'b1;
         if (result_valid && (state_q != S_WAIT)) err_q <= 1'b1;
      end
   end

   // The last datum lands during ISSUE, so the strobe cycle forwards it directly
   assign window_data  = (state_q == S_ISSUE) ? win_shift : win_q;
   assign rd_en        = rd_en_q;
   assign wb_en        = wb_en_q;
   assign wb_data      = wb_byte;
   assign window_valid = win_vld_q;
   assign flag_busy    = busy_q;
   assign flag_done    = done_q;
   assign flag_err     = err_q;

endmodule

// File: tb/tb_conv_window_sequencer.sv
// tb/tb_conv_window_sequencer.sv - directed self-checking bench for conv_window_sequencer
module tb_conv_window_sequencer;
   import conv_seq_pkg::*;

   logic             clk = 1'b0;
   logic             nrst;
   logic             ctrl_start;
   logic [15:0]      cfg_ifmap_width;
   logic [7:0]       cfg_ifmap_base, cfg_ofmap_base;
   logic             rd_en;
   logic [7:0]       rd_addr;
   logic [7:0]       rd_data = '0;
   logic             window_valid;
   logic [WIN_W-1:0] window_data;
   logic             result_valid;
   logic [RES_W-1:0] result_data;
   logic             wb_en;
   logic [7:0]       wb_addr, wb_data;
   logic             flag_busy, flag_done, flag_err;

   int total = 0, bad = 0, cyc = 0, overlap = 0, done_cnt = 0;
   logic [7:0] mem [256];
   logic [7:0] rd_q[$], wa_q[$], wd_q[$];
   logic [7:0] exp_neg;

   always #5 clk = ~clk;

   conv_window_sequencer dut (
      .clk(clk), .nrst(nrst), .ctrl_start(ctrl_start),
      .cfg_ifmap_width(cfg_ifmap_width), .cfg_ifmap_base(cfg_ifmap_base),
      .cfg_ofmap_base(cfg_ofmap_base), .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_data(rd_data), .window_valid(window_valid), .window_data(window_data),
      .result_valid(result_valid), .result_data(result_data), .wb_en(wb_en),
      .wb_addr(wb_addr), .wb_data(wb_data), .flag_busy(flag_busy),
      .flag_done(flag_done), .flag_err(flag_err)
   );

   // Unified buffer model: one-cycle read latency, logs every access
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rd_en) begin
         rd_q.push_back(rd_addr);
         rd_data <= mem[rd_addr];
      end
      if (wb_en) begin
         wa_q.push_back(wb_addr);
         wd_q.push_back(wb_data);
      end
      if (rd_en && wb_en) overlap <= overlap + 1;
      if (flag_done) done_cnt <= done_cnt + 1;
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [WIN_W-1:0] win_model(input int w, input int ox, input int oy);
      logic [WIN_W-1:0] v;
      v = '0;
      for (int ky = 0; ky < 3; ky++)
         for (int kx = 0; kx < 3; kx++)
            v[(ky*3+kx)*8 +: 8] = mem[8'((oy + ky) * w + ox + kx)];
      return v;
   endfunction

   task automatic clear_logs();
      rd_q.delete();
      wa_q.delete();
      wd_q.delete();
      done_cnt = 0;
      overlap  = 0;
   endtask

   task automatic err_run(input int w, input int ofb, input string tag);
      clear_logs();
      cfg_ifmap_width = 16'(w);
      cfg_ifmap_base  = 8'd0;
      cfg_ofmap_base  = 8'(ofb);
      ctrl_start = 1'b1;
      step();
      ctrl_start = 1'b0;
      chk({tag, "_busy_check"}, 128'(flag_busy), 128'(1));
      step();
      chk({tag, "_err"}, 128'(flag_err), 128'(1));
      chk({tag, "_busy_low"}, 128'(flag_busy), 128'(0));
      step();
      step();
      chk({tag, "_no_rd"}, 128'(rd_q.size()), 128'(0));
      chk({tag, "_no_wb"}, 128'(wa_q.size()), 128'(0));
   endtask

   task automatic run_layer(input int w, input int ofb, input int mode, input int slow_px,
                            input bit spur, input int abort_px);
      int t0, ow, guard, dly;
      logic [WIN_W-1:0] expw;
      clear_logs();
      ow = w - 2;
      cfg_ifmap_width = 16'(w);
      cfg_ifmap_base  = 8'd0;
      cfg_ofmap_base  = 8'(ofb);
      ctrl_start = 1'b1;
      t0 = cyc;
      step();
      ctrl_start = 1'b0;
      chk("check_busy", 128'(flag_busy), 128'(1));
      chk("err_cleared", 128'(flag_err), 128'(0));
      step();
      chk("first_rd_latency", 128'(rd_en), 128'(1));
      if (spur) begin
         result_valid = 1'b1;
         step();
         result_valid = 1'b0;
         chk("spurious_err", 128'(flag_err), 128'(1));
      end
      for (int p = 0; p < ow * ow; p++) begin
         guard = 0;
         while (!window_valid && guard < 200) begin
            step();
            guard++;
         end
         chk("window_valid_seen", 128'(window_valid), 128'(1));
         expw = win_model(w, p % ow, p / ow);
         chk("window_data", 128'(window_data), 128'(expw));
         step();
         dly = (p == slow_px) ? 20 : 1;
         for (int d = 1; d < dly; d++) begin
            chk("window_hold", 128'(window_data), 128'(expw));
            chk("no_wb_in_wait", 128'(wb_en), 128'(0));
            step();
         end
         result_valid = 1'b1;
         result_data  = (mode == 1) ? 24'h0007FB : {8'(3*p+2), 8'(3*p+1), 8'(3*p)};
         step();
         result_valid = 1'b0;
         if (p == abort_px) begin
            chk("abort_in_write", 128'(wb_en), 128'(1));
            nrst = 1'b0;
            #1;
            chk("abort_outputs_zero",
                128'({rd_en, wb_en, window_valid, flag_busy, flag_done, flag_err,
                      rd_addr, wb_addr, wb_data}), 128'(0));
            chk("abort_window_zero", 128'(window_data), 128'(0));
            step();
            step();
            nrst = 1'b1;
            step();
            step();
            chk("abort_writes", 128'(wa_q.size()), 128'(12));
            chk("abort_reads", 128'(rd_q.size()), 128'(45));
            chk("abort_no_done", 128'(done_cnt), 128'(0));
            chk("abort_idle", 128'(flag_busy), 128'(0));
            return;
         end
      end
      guard = 0;
      while (!flag_done && guard < 100) begin
         step();
         guard++;
      end
      chk("done_cycle", 128'(cyc - t0), 128'(2 + ow * ow * 14 + ((slow_px >= 0) ? 19 : 0)));
      step();
      chk("idle_after_done", 128'(flag_busy), 128'(0));
      chk("done_once", 128'(done_cnt), 128'(1));
      chk("no_rd_wb_overlap", 128'(overlap), 128'(0));
   endtask

   task automatic check_run_a();
      int exp0[9] = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
      int exp8[9] = '{12, 13, 14, 17, 18, 19, 22, 23, 24};
      chk("rd_count", 128'(rd_q.size()), 128'(81));
      for (int i = 0; i < 9; i++) begin
         chk("rd_px0", 128'(rd_q[i]), 128'(exp0[i]));
         chk("rd_px8", 128'(rd_q[72+i]), 128'(exp8[i]));
      end
      chk("wb_count", 128'(wa_q.size()), 128'(27));
      for (int i = 0; i < 27; i++) begin
         chk("wb_addr", 128'(wa_q[i]), 128'(100 + i));
         chk("wb_data", 128'(wd_q[i]), 128'(i));
      end
   endtask

   initial begin
`ifdef CONV_SEQ_RELU_EN
      exp_neg = 8'h00;
`else
      exp_neg = 8'hFB;
`endif
      nrst            = 1'b0;
      ctrl_start      = 1'b0;
      cfg_ifmap_width = '0;
      cfg_ifmap_base  = '0;
      cfg_ofmap_base  = '0;
      result_valid    = 1'b0;
      result_data     = '0;
      for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
      repeat (3) step();
      chk("reset_outputs",
          128'({rd_en, wb_en, window_valid, flag_busy, flag_done, flag_err,
                rd_addr, wb_addr, wb_data}), 128'(0));
      chk("reset_window", 128'(window_data), 128'(0));
      nrst = 1'b1;
      step();
      chk("idle_not_busy", 128'(flag_busy), 128'(0));

      err_run(2, 100, "small_width");

      run_layer(5, 100, 0, -1, 1'b0, -1);
      check_run_a();

      err_run(5, 250, "ofmap_bounds");

      run_layer(5, 100, 1, 0, 1'b1, -1);
      chk("sticky_err", 128'(flag_err), 128'(1));
      chk("neg_wb_count", 128'(wa_q.size()), 128'(27));
      chk("neg_ch0", 128'(wd_q[0]), 128'(exp_neg));
      chk("neg_ch1", 128'(wd_q[1]), 128'(8'd7));
      chk("neg_ch2", 128'(wd_q[2]), 128'(8'd0));
      chk("neg_last_ch0", 128'(wd_q[24]), 128'(exp_neg));
      chk("neg_last_addr", 128'(wa_q[26]), 128'(126));

      run_layer(5, 100, 0, -1, 1'b0, 4);

      run_layer(5, 100, 0, -1, 1'b0, -1);
      check_run_a();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
